// File: rtl/reg_file_scb.sv
//==============================================================================
// Module      : reg_file_scb
// Description : 32-entry architectural register file with write-through read
//               bypass and a per-register pending-write scoreboard that raises
//               a combinational issue stall on read-after-write hazards and on
//               destination counter saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_scb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  // decode-stage read ports
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  // writeback port
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  // issue interface
  input  logic              IssueValid,
  input  logic              IssueUses1,
  input  logic              IssueUses2,
  input  logic              IssueRegWrite,
  input  logic [4:0]        IssueDst,
  output logic              Stall,
  output logic              ScbErr
);

  localparam int          c_NUM_REGS = 32;
  localparam [CNT_W-1:0]  c_PEND_MAX = {CNT_W{1'b1}};
  localparam [CNT_W-1:0]  c_PEND_ONE = CNT_W'(1);

  // Flattened views of storage; entry 0 is hard-wired to zero.
  logic [DATA_W-1:0] w_regs [0:c_NUM_REGS-1];
  logic [CNT_W-1:0]  w_pend [0:c_NUM_REGS-1];

  // Write-port qualifiers shared by storage and scoreboard.
  logic w_dec;
  logic w_inc;

  // Scoreboard lookups for the two sources and the destination.
  logic [CNT_W-1:0] w_pend1;
  logic [CNT_W-1:0] w_pend2;
  logic [CNT_W-1:0] w_eff1;
  logic [CNT_W-1:0] w_eff2;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_sat;
  logic             w_err_evt;

  logic             r_scb_err;

  assign w_regs[0] = '0;
  assign w_pend[0] = '0;

  // A writeback to r0 neither stores data nor retires a pending write.
  assign w_dec = RegWrite & (WriteReg != 5'd0);

  //----------------------------------------------------------------------------
  // Per-register data storage and pending-write counter
  //----------------------------------------------------------------------------
  for (genvar i = 1; i < c_NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_pend;
    logic              w_inc_i;
    logic              w_dec_i;

    assign w_inc_i = w_inc & (IssueDst == 5'(i));
    assign w_dec_i = w_dec & (WriteReg == 5'(i));

    // Architectural value, updated by writeback.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data <= '0;
      end else if (w_dec_i) begin
        r_data <= WriteData;
      end
    end

    // In-flight write count: issue increments, writeback decrements,
    // both together cancel; an unmatched writeback leaves it at zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pend <= '0;
      end else if (w_inc_i && !w_dec_i) begin
        r_pend <= r_pend + c_PEND_ONE;
      end else if (w_dec_i && !w_inc_i && (r_pend != '0)) begin
        r_pend <= r_pend - c_PEND_ONE;
      end
    end

    assign w_regs[i] = r_data;
    assign w_pend[i] = r_pend;
  end

  //----------------------------------------------------------------------------
  // Read ports
  //----------------------------------------------------------------------------
  // Zero register, then same-cycle writeback bypass, then the array.
  always_comb begin
    ReadData1 = w_regs[ReadReg1];
    if (ReadReg1 == 5'd0) begin
      ReadData1 = '0;
    end else if (w_dec && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
    end
  end

  // Same selection for the second operand.
  always_comb begin
    ReadData2 = w_regs[ReadReg2];
    if (ReadReg2 == 5'd0) begin
      ReadData2 = '0;
    end else if (w_dec && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
    end
  end

  //----------------------------------------------------------------------------
  // Hazard detection
  //----------------------------------------------------------------------------
  assign w_pend1 = w_pend[ReadReg1];
  assign w_pend2 = w_pend[ReadReg2];
  assign w_hit1  = w_dec & (WriteReg == ReadReg1);
  assign w_hit2  = w_dec & (WriteReg == ReadReg2);

  // Effective count discounts a write retiring this cycle, since the bypass
  // already delivers its data. An unmatched writeback (count 0) must not
  // wrap the count into a phantom hazard.
  always_comb begin
    w_eff1 = w_pend1;
    w_eff2 = w_pend2;
    if (w_hit1 && (w_pend1 != '0)) begin
      w_eff1 = w_pend1 - c_PEND_ONE;
    end
    if (w_hit2 && (w_pend2 != '0)) begin
      w_eff2 = w_pend2 - c_PEND_ONE;
    end
  end

  assign w_haz1 = IssueUses1 & (ReadReg1 != 5'd0) & (w_eff1 != '0);
  assign w_haz2 = IssueUses2 & (ReadReg2 != 5'd0) & (w_eff2 != '0);

  // Saturation uses the registered count: a retiring write this cycle does
  // not free a slot until the next edge, which keeps the counter from ever
  // needing to exceed its maximum.
  assign w_sat = IssueRegWrite & (w_pend[IssueDst] == c_PEND_MAX);

  assign Stall = IssueValid & (w_haz1 | w_haz2 | w_sat);

  // Only accepted (non-stalled) issues with a real destination are tracked.
  assign w_inc = IssueValid & IssueRegWrite & (IssueDst != 5'd0) & ~Stall;

  //----------------------------------------------------------------------------
  // Sticky scoreboard error
  //----------------------------------------------------------------------------
  assign w_err_evt = w_dec & (w_pend[WriteReg] == '0);

  // Latch any writeback that had no matching pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scb_err <= 1'b0;
    end else if (w_err_evt) begin
      r_scb_err <= 1'b1;
    end
  end

  assign ScbErr = r_scb_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_scb.sv
//==============================================================================
// Module      : tb_reg_file_scb
// Description : Directed, table-driven bench for reg_file_scb. Each table row
//               is one clock cycle of stimulus with the outputs expected
//               before the rising edge of that cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_file_scb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg, IssueDst;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite, IssueValid, IssueUses1, IssueUses2, IssueRegWrite;
  logic        Stall, ScbErr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_scb #(.DATA_W(32), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .IssueValid   (IssueValid),
    .IssueUses1   (IssueUses1),
    .IssueUses2   (IssueUses2),
    .IssueRegWrite(IssueRegWrite),
    .IssueDst     (IssueDst),
    .Stall        (Stall),
    .ScbErr       (ScbErr)
  );

  typedef struct {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic        u1;
    logic        u2;
    logic        irw;
    logic [4:0]  dst;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] rr1, input logic [4:0] rr2,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic iv, input logic u1, input logic u2,
                     input logic irw, input logic [4:0] dst,
                     input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                     input logic e_stall, input logic e_err);
    vec_t v;
    v.rr1 = rr1; v.rr2 = rr2; v.we = we; v.wr = wr; v.wd = wd;
    v.iv = iv; v.u1 = u1; v.u2 = u2; v.irw = irw; v.dst = dst;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_stall = e_stall; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    ReadReg1 = v.rr1; ReadReg2 = v.rr2;
    RegWrite = v.we;  WriteReg = v.wr; WriteData = v.wd;
    IssueValid = v.iv; IssueUses1 = v.u1; IssueUses2 = v.u2;
    IssueRegWrite = v.irw; IssueDst = v.dst;
  endtask

  task automatic idle();
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
    IssueValid = 1'b0; IssueUses1 = 1'b0; IssueUses2 = 1'b0;
    IssueRegWrite = 1'b0; IssueDst = 5'd0;
  endtask

  task automatic check(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input vec_t v);
    check("rd1",   row, ReadData1, v.e_rd1);
    check("rd2",   row, ReadData2, v.e_rd2);
    check("stall", row, {31'b0, Stall},  {31'b0, v.e_stall});
    check("err",   row, {31'b0, ScbErr}, {31'b0, v.e_err});
  endtask

  initial begin
    //   rr1 rr2 we wr  wd            iv u1 u2 irw dst  e_rd1         e_rd2         st er
    // reset state as seen after release
    add( 5, 31, 0, 0, 32'h0,        0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0); // 0
    // track a write to r5, then retire it with DEADBEEF
    add( 5,  0, 0, 0, 32'h0,        1, 0, 0, 1,  5,  32'h0,        32'h0,        0, 0); // 1
    add( 5,  0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0); // 2 bypass
    add( 5,  0, 0, 0, 32'h0,        0, 0, 0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0); // 3 array
    // write to r0 is ignored and is not a scoreboard error
    add( 0,  0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0); // 4
    add( 0,  5, 0, 0, 32'h0,        0, 0, 0, 0,  0,  32'h0,        32'hDEADBEEF, 0, 0); // 5
    // same-cycle write-through on r7
    add( 7,  0, 0, 0, 32'h0,        1, 0, 0, 1,  7,  32'h0,        32'h0,        0, 0); // 6
    add( 7,  7, 1, 7, 32'h1234,     0, 0, 0, 0,  0,  32'h1234,     32'h1234,     0, 0); // 7
    add( 7,  0, 0, 0, 32'h0,        0, 0, 0, 0,  0,  32'h1234,     32'h0,        0, 0); // 8
    // RAW on r3: stall, then released by writeback in the reader's cycle
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  3,  32'h0,        32'h0,        0, 0); // 9
    add( 3,  0, 0, 0, 32'h0,        1, 1, 0, 0,  0,  32'h0,        32'h0,        1, 0); // 10
    add( 3,  0, 1, 3, 32'hCAFE,     1, 1, 0, 0,  0,  32'hCAFE,     32'h0,        0, 0); // 11
    add( 0,  3, 0, 0, 32'h0,        1, 0, 1, 0,  0,  32'h0,        32'hCAFE,     0, 0); // 12
    // pending r3 but operand unused / no valid issue: no stall
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  3,  32'h0,        32'h0,        0, 0); // 13
    add( 3,  0, 0, 0, 32'h0,        1, 0, 0, 0,  0,  32'hCAFE,     32'h0,        0, 0); // 14
    add( 3,  3, 0, 0, 32'h0,        0, 1, 1, 0,  0,  32'hCAFE,     32'hCAFE,     0, 0); // 15
    add( 3,  0, 1, 3, 32'hBEEF,     0, 0, 0, 0,  0,  32'hBEEF,     32'h0,        0, 0); // 16
    // saturate r9 (max 3 in flight)
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        0, 0); // 17
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        0, 0); // 18
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        0, 0); // 19
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        1, 0); // 20
    // same-cycle writeback does not relieve saturation until the edge
    add( 9,  0, 1, 9, 32'h99,       1, 0, 0, 1,  9,  32'h99,       32'h0,        1, 0); // 21
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        0, 0); // 22
    add( 0,  0, 0, 0, 32'h0,        1, 0, 0, 1,  9,  32'h0,        32'h0,        1, 0); // 23
    // unmatched writeback to r12: sticky error
    add(12,  0, 1,12, 32'h12,       0, 0, 0, 0,  0,  32'h12,       32'h0,        0, 0); // 24
    add(12,  0, 0, 0, 32'h0,        0, 0, 0, 0,  0,  32'h12,       32'h0,        0, 1); // 25
    add(12,  9, 0, 0, 32'h0,        1, 1, 0, 0,  0,  32'h12,       32'h99,       0, 1); // 26

    // asynchronous reset and check cleared state while held
    idle();
    reset = 1'b1;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd7;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd1", -1, ReadData1, 32'h0);
    check("rst_rd2", -1, ReadData2, 32'h0);
    check("rst_stall", -1, {31'b0, Stall}, 32'h0);
    check("rst_err", -1, {31'b0, ScbErr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_all(i, vecs[i]);
    end

    // mid-operation reset, asserted away from any clock edge
    @(negedge clk);
    idle();
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd7;
    #1;
    check("pre_rst_rd1", 100, ReadData1, 32'hDEADBEEF);
    check("pre_rst_err", 100, {31'b0, ScbErr}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rd1", 101, ReadData1, 32'h0);
    check("mid_rst_rd2", 101, ReadData2, 32'h0);
    check("mid_rst_err", 101, {31'b0, ScbErr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // counters cleared: reader of r9/r3 and a writer to r9 go straight through
    IssueValid = 1'b1;
    IssueUses1 = 1'b1; ReadReg1 = 5'd9;
    IssueUses2 = 1'b1; ReadReg2 = 5'd3;
    IssueRegWrite = 1'b1; IssueDst = 5'd9;
    #1;
    check("post_rst_stall", 102, {31'b0, Stall}, 32'h0);
    check("post_rst_rd1", 102, ReadData1, 32'h0);

    // the accepted issue is now pending: a reader of r9 stalls
    @(negedge clk);
    IssueRegWrite = 1'b0;
    IssueDst = 5'd0;
    #1;
    check("post_rst_raw", 103, {31'b0, Stall}, 32'h1);
    check("post_rst_err", 103, {31'b0, ScbErr}, 32'h0);

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
